// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR tap sequencer and its ALU interface.
package fir_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StRun,
    StDrain
  } fir_state_e;

  localparam int unsigned DefaultDw = 16;
  localparam int unsigned DefaultCw = 16;
  // Width of the downstream ALU accumulator output y.
  localparam int unsigned ACCW      = 39;

endpackage

// File: rtl/fir_delay_line.sv
// Sample delay line: tap 0 holds the newest sample; shifts one tap per enabled cycle.
module fir_delay_line #(
  parameter int unsigned NTAPS = 16,
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = $clog2(NTAPS)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          shift_en_i,
  input  logic [DW-1:0] sample_i,
  input  logic [AW-1:0] rd_idx_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] dline_q [NTAPS];
  logic [DW-1:0] dline_d [NTAPS];

  always_comb begin
    dline_d = dline_q;
    if (shift_en_i) begin
      dline_d[0] = sample_i;
      for (int unsigned k = 1; k < NTAPS; k++) begin
        dline_d[k] = dline_q[k-1];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dline_q <= '{default: '0};
    end else begin
      dline_q <= dline_d;
    end
  end

  assign rd_data_o = dline_q[rd_idx_i];

endmodule

// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: accepts a sample, clears the MAC ALU, streams NTAPS (x, coef) pairs,
// then flags the cycle in which the ALU output holds the finished sum.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS   = 16,
  parameter int unsigned DW      = DefaultDw,
  parameter int unsigned CW      = DefaultCw,
  parameter int unsigned AW      = $clog2(NTAPS),
  parameter int unsigned MAC_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_sample,
  input  logic          coef_we,
  input  logic [AW-1:0] coef_addr,
  input  logic [CW-1:0] coef_wdata,
  output logic [DW-1:0] X,
  output logic [CW-1:0] B,
  output logic          R,
  output logic          busy,
  output logic          acc_done,
  output logic          coef_err
);

  localparam int unsigned      DcntW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [AW-1:0]    KLast = AW'(NTAPS - 1);
  localparam logic [DcntW-1:0] DLast = DcntW'(MAC_LAT - 1);

  fir_state_e       state_q, state_d;
  logic [AW-1:0]    k_q, k_d;
  logic [DcntW-1:0] dcnt_q, dcnt_d;
  logic [CW-1:0]    coef_q [NTAPS];
  logic [CW-1:0]    coef_d [NTAPS];

  logic          dl_shift;
  logic [DW-1:0] dl_rdata;
  logic          addr_oor, coef_wr;

  logic [DW-1:0] x_q, x_d;
  logic [CW-1:0] b_q, b_d;
  logic          r_q, r_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;
  logic          acc_done_q, acc_done_d;
  logic          coef_err_q, coef_err_d;

  fir_delay_line #(
    .NTAPS (NTAPS),
    .DW    (DW),
    .AW    (AW)
  ) u_dline (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .shift_en_i (dl_shift),
    .sample_i   (in_sample),
    .rd_idx_i   (k_d),
    .rd_data_o  (dl_rdata)
  );

  // in_ready_q gates the handshake so the first cycle after reset cannot accept.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    dcnt_d   = dcnt_q;
    dl_shift = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready_q) begin
          dl_shift = 1'b1;
          state_d  = StClear;
        end
      end
      StClear: begin
        state_d = StRun;
        k_d     = '0;
      end
      StRun: begin
        if (k_q == KLast) begin
          state_d = StDrain;
          dcnt_d  = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDrain: begin
        if (dcnt_q == DLast) begin
          state_d = StIdle;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign addr_oor = 32'(coef_addr) >= NTAPS;
  assign coef_wr  = coef_we && (state_q == StIdle) && !addr_oor;

  always_comb begin
    coef_d = coef_q;
    if (coef_wr) begin
      coef_d[coef_addr] = coef_wdata;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    x_d = '0;
    b_d = '0;
    if (state_d == StRun) begin
      x_d = dl_rdata;
      b_d = coef_q[k_d];
    end
    r_d        = (state_d == StClear);
    in_ready_d = (state_d == StIdle);
    busy_d     = (state_d != StIdle);
    acc_done_d = (state_d == StDrain) && (dcnt_d == DLast);
    coef_err_d = coef_err_q | (coef_we & ~coef_wr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      k_q        <= '0;
      dcnt_q     <= '0;
      coef_q     <= '{default: '0};
      x_q        <= '0;
      b_q        <= '0;
      r_q        <= 1'b1;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      acc_done_q <= 1'b0;
      coef_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      dcnt_q     <= dcnt_d;
      coef_q     <= coef_d;
      x_q        <= x_d;
      b_q        <= b_d;
      r_q        <= r_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      acc_done_q <= acc_done_d;
      coef_err_q <= coef_err_d;
    end
  end

  assign X        = x_q;
  assign B        = b_q;
  assign R        = r_q;
  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign acc_done = acc_done_q;
  assign coef_err = coef_err_q;

endmodule
